// File: rtl/bp_profiler_pkg.sv
// Shared types and constants for the event profiler slice: the read FSM
// state encoding, the snapshot sequence width and a clog2 helper.
package bp_profiler_pkg;

    localparam int snap_seq_width_gp = 16;

    typedef enum logic [1:0] {
        e_prof_idle,
        e_prof_busy,
        e_prof_valid
    } bp_prof_rd_state_e;

    // clog2 that never returns 0, so a single-entry bank still has a 1-bit index
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bp_event_profiler_if.sv
// Snapshot and indexed-read handshake between the profiler (slave) and the
// host shell (master).
interface bp_event_profiler_if
    import bp_profiler_pkg::*;
#(
    parameter int els_p   = 80,
    parameter int width_p = 32
) ();

    localparam int lg_els_lp = safe_clog2(els_p);

    logic                         snap_v_i;
    logic                         snap_clear_i;
    logic                         snap_ready_o;
    logic [snap_seq_width_gp-1:0] snap_seq_o;

    logic                         rd_v_i;
    logic [lg_els_lp-1:0]         rd_addr_i;
    logic                         rd_ready_o;
    logic                         rd_v_o;
    logic [width_p-1:0]           rd_data_o;
    logic                         rd_ovf_o;
    logic                         rd_yumi_i;

    modport slave (
        input  snap_v_i, snap_clear_i, rd_v_i, rd_addr_i, rd_yumi_i,
        output snap_ready_o, snap_seq_o, rd_ready_o, rd_v_o, rd_data_o, rd_ovf_o
    );

    modport master (
        output snap_v_i, snap_clear_i, rd_v_i, rd_addr_i, rd_yumi_i,
        input  snap_ready_o, snap_seq_o, rd_ready_o, rd_v_o, rd_data_o, rd_ovf_o
    );

endinterface

// File: rtl/bp_event_counter.sv
// One profiler lane: live counter plus sticky overflow flag. The updated
// value (after freeze and increment, before any snapshot clear) is exported
// so the top can capture exactly what the live register would have taken.
module bp_event_counter
    import bp_profiler_pkg::*;
#(
    parameter int width_p      = 32,
    parameter int incr_width_p = 2,
    parameter int saturate_p   = 0
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    freeze_i,
    input  logic                    clear_i,
    input  logic                    inc_en_i,
    input  logic [incr_width_p-1:0] incr_i,
    output logic [width_p-1:0]      upd_cnt_o,
    output logic                    upd_ovf_o
);

    logic [width_p-1:0] cnt_reg;
    logic               ovf_reg;
    logic [width_p:0]   sum;

    // Next value ignoring the snapshot clear: freeze first, then add with carry detect
    always_comb begin
        sum       = {1'b0, cnt_reg} + (width_p + 1)'(incr_i);
        upd_cnt_o = cnt_reg;
        upd_ovf_o = ovf_reg;
        if (freeze_i) begin
            upd_cnt_o = '0;
            upd_ovf_o = 1'b0;
        end else if (inc_en_i) begin
            if (sum[width_p]) begin
                upd_cnt_o = (saturate_p != 0) ? {width_p{1'b1}} : sum[width_p-1:0];
                upd_ovf_o = 1'b1;
            end else begin
                upd_cnt_o = sum[width_p-1:0];
            end
        end
    end

    // Live state; a clearing snapshot zeroes it after the shadow took the update
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            cnt_reg <= '0;
            ovf_reg <= 1'b0;
        end else if (clear_i) begin
            cnt_reg <= '0;
            ovf_reg <= 1'b0;
        end else begin
            cnt_reg <= upd_cnt_o;
            ovf_reg <= upd_ovf_o;
        end
    end

endmodule

// File: rtl/bp_event_profiler.sv
// Event profiler: els_p counting lanes, an atomic shadow snapshot and a
// three-state indexed read port. Optional auto-snapshot on a cycle interval
// is enabled by defining BP_EVENT_PROFILER_INTERVAL_EN.
module bp_event_profiler
    import bp_profiler_pkg::*;
#(
    parameter int els_p        = 80,
    parameter int width_p      = 32,
    parameter int incr_width_p = 2,
    parameter int saturate_p   = 0
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          freeze_i,
    input  logic                          en_i,
    input  logic [els_p-1:0]              mask_i,
    input  logic [els_p*incr_width_p-1:0] incr_i,
`ifdef BP_EVENT_PROFILER_INTERVAL_EN
    input  logic [width_p-1:0]            interval_i,
`endif
    bp_event_profiler_if.slave            bus
);

    localparam int lg_els_lp = safe_clog2(els_p);
    localparam logic [lg_els_lp:0] els_w_lp = (lg_els_lp + 1)'(els_p);

    bp_prof_rd_state_e            state_reg;
    logic [lg_els_lp-1:0]         addr_reg;
    logic                         rd_ready_reg;
    logic                         snap_ready_reg;
    logic                         rd_v_reg;
    logic [width_p-1:0]           rd_data_reg;
    logic                         rd_ovf_reg;
    logic [snap_seq_width_gp-1:0] snap_seq_reg;

    logic [width_p-1:0] upd_cnt    [els_p];
    logic               upd_ovf    [els_p];
    logic [width_p-1:0] shadow_cnt [els_p];
    logic               shadow_ovf [els_p];

    logic               snap_req;
    logic               snap_clear;
    logic               snap_fire;
    logic               live_clear;
    logic [width_p-1:0] mux_data;
    logic               mux_ovf;

`ifdef BP_EVENT_PROFILER_INTERVAL_EN
    logic [width_p-1:0] cyc_reg;
    logic               pend_reg;
    logic               auto_hit;
    logic               auto_req;

    // Auto request fires on the last cycle of each interval or while one is pending
    always_comb begin
        auto_hit   = en_i && (interval_i != '0) && (cyc_reg == interval_i - width_p'(1));
        auto_req   = pend_reg | auto_hit;
        snap_req   = bus.snap_v_i | auto_req;
        snap_clear = (bus.snap_v_i & bus.snap_clear_i) | auto_req;
    end

    // Interval counter restarts at request time; pending holds a blocked request
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            cyc_reg  <= '0;
            pend_reg <= 1'b0;
        end else begin
            if (auto_hit) begin
                cyc_reg <= '0;
            end else if (en_i && (interval_i != '0)) begin
                cyc_reg <= cyc_reg + width_p'(1);
            end
            if (snap_fire) begin
                pend_reg <= 1'b0;
            end else if (auto_hit) begin
                pend_reg <= 1'b1;
            end
        end
    end
`else
    // Snapshots come only from the external request
    always_comb begin
        snap_req   = bus.snap_v_i;
        snap_clear = bus.snap_clear_i;
    end
`endif

    assign snap_fire  = snap_req & snap_ready_reg;
    assign live_clear = snap_fire & snap_clear;

    for (genvar gi = 0; gi < els_p; gi++) begin : g_lane
        bp_event_counter #(
            .width_p      (width_p),
            .incr_width_p (incr_width_p),
            .saturate_p   (saturate_p)
        ) u_counter (
            .clk_i     (clk_i),
            .reset_n_i (reset_n_i),
            .freeze_i  (freeze_i),
            .clear_i   (live_clear),
            .inc_en_i  (en_i & mask_i[gi]),
            .incr_i    (incr_i[gi*incr_width_p +: incr_width_p]),
            .upd_cnt_o (upd_cnt[gi]),
            .upd_ovf_o (upd_ovf[gi])
        );
    end

    // Shadow bank captures every lane's updated value in the fire cycle
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < els_p; i++) begin
            if (!reset_n_i) begin
                shadow_cnt[i] <= '0;
                shadow_ovf[i] <= 1'b0;
            end else if (snap_fire) begin
                shadow_cnt[i] <= upd_cnt[i];
                shadow_ovf[i] <= upd_ovf[i];
            end
        end
    end

    // Snapshot sequence number, advanced once per accepted snapshot
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            snap_seq_reg <= '0;
        end else if (snap_fire) begin
            snap_seq_reg <= snap_seq_reg + snap_seq_width_gp'(1);
        end
    end

    // Shadow mux; addresses past the bank read as zero
    always_comb begin
        mux_data = '0;
        mux_ovf  = 1'b0;
        if ({1'b0, addr_reg} < els_w_lp) begin
            mux_data = shadow_cnt[addr_reg];
            mux_ovf  = shadow_ovf[addr_reg];
        end
    end

    // Read FSM with registered handshake outputs; snapshots allowed only in IDLE
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_reg      <= e_prof_idle;
            addr_reg       <= '0;
            rd_ready_reg   <= 1'b1;
            snap_ready_reg <= 1'b1;
            rd_v_reg       <= 1'b0;
            rd_data_reg    <= '0;
            rd_ovf_reg     <= 1'b0;
        end else begin
            case (state_reg)
                e_prof_idle: begin
                    if (bus.rd_v_i) begin
                        addr_reg       <= bus.rd_addr_i;
                        state_reg      <= e_prof_busy;
                        rd_ready_reg   <= 1'b0;
                        snap_ready_reg <= 1'b0;
                    end
                end
                e_prof_busy: begin
                    rd_data_reg <= mux_data;
                    rd_ovf_reg  <= mux_ovf;
                    rd_v_reg    <= 1'b1;
                    state_reg   <= e_prof_valid;
                end
                e_prof_valid: begin
                    if (bus.rd_yumi_i) begin
                        rd_v_reg       <= 1'b0;
                        rd_ready_reg   <= 1'b1;
                        snap_ready_reg <= 1'b1;
                        state_reg      <= e_prof_idle;
                    end
                end
                default: begin
                    state_reg      <= e_prof_idle;
                    rd_v_reg       <= 1'b0;
                    rd_ready_reg   <= 1'b1;
                    snap_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign bus.rd_ready_o   = rd_ready_reg;
    assign bus.snap_ready_o = snap_ready_reg;
    assign bus.rd_v_o       = rd_v_reg;
    assign bus.rd_data_o    = rd_data_reg;
    assign bus.rd_ovf_o     = rd_ovf_reg;
    assign bus.snap_seq_o   = snap_seq_reg;

endmodule
